// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial LSL and
// shift-add MUL, sequenced by an IDLE/EXEC/DONE FSM with registered result and flags.
module alu_multiciclo #(
    parameter int N      = 32,
    parameter int MUL_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   ALUControl,
    input  logic         setFlags,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] out,
    output logic [3:0]   ALUFlags
);

    localparam int SW = $clog2(N);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_XOR, OP_NOT, OP_AND, OP_OR, OP_LSL, OP_MUL
    } op_t;

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, out_q, out_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     flags_q, flags_d;
    logic           sf_q, sf_d, shc_q, shc_d;

    logic [N:0]     sum;
    logic [N-1:0]   diff, res;
    logic           fc, fv;

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = a_q - b_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
            sf_q    <= 1'b0;
            shc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            sf_q    <= sf_d;
            shc_q   <= shc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;
        sf_d    = sf_q;
        shc_d   = shc_q;
        res     = '0;
        fc      = flags_q[1];
        fv      = flags_q[0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EXEC;
                    a_d     = A;
                    b_d     = B;
                    sf_d    = setFlags;
                    shc_d   = flags_q[1];
                    op_d    = op_t'(ALUControl);
                    if (op_d == OP_MUL && MUL_EN == 0) op_d = OP_ADD;
                    acc_d   = (op_d == OP_MUL) ? '0 : A;
                    case (op_d)
                        OP_MUL:  cnt_d = CW'(N);
                        OP_LSL:  cnt_d = (B[SW-1:0] == '0) ? CW'(1) : CW'(B[SW-1:0]);
                        default: cnt_d = CW'(1);
                    endcase
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CW'(1);
                // LSL walks acc one bit per cycle; MUL shifts a_q/b_q as multiplicand/multiplier
                if (op_q == OP_LSL && b_q[SW-1:0] != '0) begin
                    acc_d = acc_q << 1;
                    shc_d = acc_q[N-1];
                end else if (op_q == OP_MUL) begin
                    if (b_q[0]) acc_d = acc_q + a_q;
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    case (op_q)
                        OP_ADD: begin
                            res = sum[N-1:0];
                            fc  = sum[N];
                            fv  = (a_q[N-1] == b_q[N-1]) && (res[N-1] != a_q[N-1]);
                        end
                        OP_SUB: begin
                            res = diff;
                            fc  = (a_q >= b_q);
                            fv  = (a_q[N-1] != b_q[N-1]) && (res[N-1] != a_q[N-1]);
                        end
                        OP_XOR:  res = a_q ^ b_q;
                        OP_NOT:  res = ~a_q;
                        OP_AND:  res = a_q & b_q;
                        OP_OR:   res = a_q | b_q;
                        OP_LSL: begin
                            res = acc_d;
                            fc  = shc_d;
                        end
                        default: res = acc_d;
                    endcase
                    out_d = res;
                    if (sf_q) flags_d = {res[N-1], (res == '0), fc, fv};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == EXEC);
    assign done     = (state_q == DONE);
    assign out      = out_q;
    assign ALUFlags = flags_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo: an independent model queues expected
// result/flags/busy-length per operation; a monitor compares on each done pulse.
module tb_alu_multiciclo;

    localparam int N = 32;

    typedef struct {
        logic [N-1:0] res;
        logic [3:0]   fl;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] A, B;
    logic [2:0]   ALUControl;
    logic         setFlags;
    logic         busy, done;
    logic [N-1:0] out;
    logic [3:0]   ALUFlags;

    int   total = 0;
    int   bad   = 0;
    int   bcnt  = 0;
    logic [3:0] mflags = 4'b0000;
    exp_t q[$];

    alu_multiciclo #(.N(N), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .ALUControl(ALUControl), .setFlags(setFlags),
        .busy(busy), .done(done), .out(out), .ALUFlags(ALUFlags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: wide arithmetic, independent of the iterative datapath
    function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] a,
                                   input logic [N-1:0] b, input logic sf);
        exp_t        e;
        logic [N:0]  s;
        logic [63:0] p;
        logic        c, v;
        int          sh;
        c = mflags[1];
        v = mflags[0];
        sh = int'(b[4:0]);
        e.cyc = 1;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[N-1:0]; c = s[N];
                        v = (a[N-1] == b[N-1]) && (e.res[N-1] != a[N-1]); end
            3'd1: begin e.res = a - b; c = (a >= b);
                        v = (a[N-1] != b[N-1]) && (e.res[N-1] != a[N-1]); end
            3'd2: e.res = a ^ b;
            3'd3: e.res = ~a;
            3'd4: e.res = a & b;
            3'd5: e.res = a | b;
            3'd6: begin
                p = {32'b0, a} << sh;
                e.res = p[N-1:0];
                if (sh != 0) c = p[N];
                e.cyc = (sh == 0) ? 1 : sh;
            end
            default: begin p = {32'b0, a} * {32'b0, b}; e.res = p[N-1:0]; e.cyc = N; end
        endcase
        if (sf) mflags = {e.res[N-1], (e.res == '0), c, v};
        e.fl = mflags;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) bcnt = 0;
        else begin
            if (busy) bcnt++;
            if (done) begin
                if (q.size() == 0) check("spurious_done", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out", out, e.res);
                    check("flags", ALUFlags, e.fl);
                    check("busy_cycles", bcnt, e.cyc);
                end
                bcnt = 0;
            end
        end
    end

    // Drive one op, scramble inputs after acceptance, optionally pulse start mid-EXEC
    task automatic issue(input logic [2:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic sf, input bit poke);
        bit seen;
        q.push_back(model(op, a, b, sf));
        start = 1'b1; ALUControl = op; A = a; B = b; setFlags = sf;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom; ALUControl = 3'($urandom); setFlags = ~sf;
        seen = done;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (poke && (i == 3 || i == 12)) start = 1'b1;
            else start = 1'b0;
            seen = done;
        end
        start = 1'b0;
        if (!seen) check("timeout_done", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; A = '0; B = '0; ALUControl = '0; setFlags = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out", out, 0);
        check("rst_flags", ALUFlags, 0);
        reset = 1'b1;
        @(negedge clk);

        issue(3'd0, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0);
        issue(3'd2, 32'h00001234, 32'h000000FF, 1'b0, 1'b0);
        issue(3'd1, 32'h00000005, 32'h00000005, 1'b1, 1'b0);
        issue(3'd1, 32'h00000000, 32'h00000001, 1'b1, 1'b0);
        issue(3'd6, 32'h80000001, 32'h00000004, 1'b1, 1'b0);
        issue(3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
        issue(3'd6, 32'h80000001, 32'h00000000, 1'b1, 1'b0);
        issue(3'd6, 32'h00000003, 32'h0000001F, 1'b1, 1'b0);
        issue(3'd7, 32'h0000FFFF, 32'h00010001, 1'b1, 1'b1);
        issue(3'd3, 32'h0F0F0F0F, 32'h0, 1'b1, 1'b0);
        issue(3'd4, 32'hF0F0FFFF, 32'h0FF0F00F, 1'b1, 1'b0);
        issue(3'd5, 32'h80000000, 32'h00000001, 1'b1, 1'b0);
        issue(3'd1, 32'h80000000, 32'h00000001, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            issue(3'($urandom), $urandom, $urandom, 1'($urandom), 1'b0);

        // Abort a MUL at its tenth EXEC cycle
        start = 1'b1; ALUControl = 3'd7; A = 32'h12345678; B = 32'h9ABCDEF1; setFlags = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("mul_busy_before_abort", busy, 1);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_out", out, 0);
        check("abort_flags", ALUFlags, 0);
        mflags = 4'b0000;
        repeat (2) @(negedge clk);
        q.push_back(model(3'd0, 32'h00000010, 32'h00000020, 1'b1));
        start = 1'b1; ALUControl = 3'd0; A = 32'h00000010; B = 32'h00000020; setFlags = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("accept_first_edge", busy, 1);
        start = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_multiciclo.md
ALU_MULTICICLO -- requirements
Module: alu_multiciclo

Interface
REQ-001 Parameter N, default 32, data width in bits; legal range 8 to 64, power of two.
REQ-002 Parameter MUL_EN, default 1, 1 includes the iterative multiplier; 0 makes MUL behave as ADD.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 A  input  N  operand A, latched on accepted start.
REQ-007 B  input  N  operand B, latched on accepted start; B[log2(N)-1:0] is the shift amount for LSL.
REQ-008 ALUControl  input  3  operation select, latched on accepted start.
REQ-009 setFlags  input  1  1 = update ALUFlags at completion; latched on accepted start.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse marking valid result.
REQ-012 out  output  N  registered result, held until the next completion.
REQ-013 ALUFlags  output  4  registered flags {N,Z,C,V}, held between updates.

Function
REQ-014 ALUControl encoding: 000 ADD, 001 SUB (A-B), 010 XOR, 011 NOT (~A), 100 AND, 101 OR, 110 LSL (A << shamt), 111 MUL (low N bits of A*B).
REQ-015 FSM states: IDLE, EXEC, DONE; IDLE->EXEC on start; EXEC->DONE when the iteration count reaches zero; DONE->IDLE unconditionally after one cycle.
REQ-016 busy is high in EXEC only; done is high in DONE only; out and ALUFlags change only on the EXEC->DONE edge.
REQ-017 ADD/SUB/XOR/NOT/AND/OR: one EXEC cycle; start-to-done latency 2 cycles.
REQ-018 LSL: one bit per EXEC cycle; EXEC lasts max(shamt,1) cycles; shamt 0 gives out = A.
REQ-019 MUL (MUL_EN=1): shift-add, one multiplier bit per cycle, EXEC lasts exactly N cycles; upper product bits discarded.
REQ-020 start while busy or in DONE is ignored, with no effect on the latched operands.
REQ-021 Flag N = out[N-1]; Z = 1 iff out == 0; both are computed for every operation.
REQ-022 Flag C for ADD is the carry-out of bit N-1.
REQ-023 Flag C for SUB is NOT borrow, i.e. 1 iff A >= B unsigned.
REQ-024 Flag C for LSL is the last bit shifted out; C is unchanged when shamt = 0.
REQ-025 Flag C for XOR/NOT/AND/OR/MUL is unchanged.
REQ-026 Flag V for ADD = (A[N-1]==B[N-1]) & (out[N-1]!=A[N-1]).
REQ-027 Flag V for SUB = (A[N-1]!=B[N-1]) & (out[N-1]!=A[N-1]).
REQ-028 Flag V for all other operations is unchanged.
REQ-029 When setFlags = 0, ALUFlags holds all four bits; out still updates.
REQ-030 All arithmetic is modulo 2^N; no saturation.

Reset
REQ-031 reset low asynchronously forces IDLE, busy=0, done=0, out=0, ALUFlags=4'b0000, and clears the iteration counter.
REQ-032 reset asserted mid-EXEC aborts the operation; no done pulse occurs and out/ALUFlags stay at reset values.
REQ-033 After reset release, the first rising edge with start=1 is accepted.

Verification
REQ-034 N=32, ADD A=7FFFFFFF, B=00000001, setFlags=1 -> done at cycle 2, out=80000000, ALUFlags=1001.
REQ-035 SUB A=00000005, B=00000005, setFlags=1 -> out=0, ALUFlags=0110; then SUB 0-1 -> out=FFFFFFFF, ALUFlags=1000.
REQ-036 LSL A=80000001, B=4 -> busy for 4 cycles, out=00000010, C=0 (last bit shifted out), N/Z updated; then LSL with B=0 -> out=A, C unchanged.
REQ-037 MUL A=0000FFFF, B=00010001 -> busy exactly 32 cycles, out=FFFFFFFF; start pulses mid-EXEC are ignored.
REQ-038 XOR with setFlags=0 after the REQ-034 state -> out updates, ALUFlags remains 1001.
REQ-039 reset low at EXEC cycle 10 of a MUL -> busy=0, no done, out=0, ALUFlags=0000; a fresh ADD is accepted on the first edge after release.
